// File: rtl/psum_wb_pkg.sv
// Shared types and helpers for the psum writeback path.
// State encoding and a width-generic signed saturating add.
package psum_wb_pkg;

    localparam int COL     = 8;
    localparam int PSUM_BW = 16;
    localparam int ADDR_W  = 11;
    localparam int CNT_W   = 11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PASS   = 3'd1,
        ACC_RD = 3'd2,
        ACC_WR = 3'd3,
        DONE   = 3'd4
    } wb_state_t;

    // Operands arrive sign-extended to 32 bits; result is clamped to bw bits.
    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input int          bw
    );
        logic signed [32:0] s;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        s  = $signed({a[31], a}) + $signed({b[31], b});
        hi = (33'sd1 <<< (bw - 1)) - 33'sd1;
        lo = -(33'sd1 <<< (bw - 1));
        if (s > hi)
            s = hi;
        else if (s < lo)
            s = lo;
        return s[31:0];
    endfunction

endpackage

// File: rtl/psum_writeback_lane.sv
// Single-lane signed saturating adder used for psum accumulation.
// Replicated once per column by psum_writeback.
module psum_sat_add_lane
    import psum_wb_pkg::*;
#(
    parameter int psum_bw = PSUM_BW
) (
    input  logic [psum_bw-1:0] a,
    input  logic [psum_bw-1:0] b,
    output logic [psum_bw-1:0] y
);

    logic [31:0] wide;
    logic        wide_unused;

    assign wide = sat_add({{(32-psum_bw){a[psum_bw-1]}}, a},
                          {{(32-psum_bw){b[psum_bw-1]}}, b},
                          psum_bw);

    assign y           = wide[psum_bw-1:0];
    assign wide_unused = ^wide[31:psum_bw];

endmodule

// File: rtl/psum_writeback.sv
// Drains OFIFO result vectors into the psum SRAM, either
// overwriting or read-add-writing with lane-wise saturation.
module psum_writeback
    import psum_wb_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int addr_w  = ADDR_W,
    parameter int cnt_w   = CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [addr_w-1:0]      base_addr,
    input  logic [cnt_w-1:0]       num_vec,
    input  logic                   accum_en,
    input  logic                   ofifo_valid,
    input  logic [col*psum_bw-1:0] ofifo_data,
    output logic                   ofifo_rd,
    output logic                   sram_cen,
    output logic                   sram_wen,
    output logic [addr_w-1:0]      sram_a,
    output logic [col*psum_bw-1:0] sram_d,
    input  logic [col*psum_bw-1:0] sram_q,
    output logic                   busy,
    output logic                   done
);

    localparam int W = col * psum_bw;

    wb_state_t         state;
    wb_state_t         state_nx;
    logic [addr_w-1:0] addr;
    logic [addr_w-1:0] addr_nx;
    logic [cnt_w-1:0]  remaining;
    logic [cnt_w-1:0]  remaining_nx;
    logic [W-1:0]      hold;
    logic [W-1:0]      hold_nx;
    logic [W-1:0]      acc_sum;
    logic              last;

    for (genvar k = 0; k < col; k++) begin : g_lane
        psum_sat_add_lane #(
            .psum_bw(psum_bw)
        ) u_lane (
            .a(sram_q[k*psum_bw +: psum_bw]),
            .b(hold[k*psum_bw +: psum_bw]),
            .y(acc_sum[k*psum_bw +: psum_bw])
        );
    end

    assign last   = (remaining == cnt_w'(1));
    assign sram_a = addr;

    always_comb begin
        state_nx     = state;
        addr_nx      = addr;
        remaining_nx = remaining;
        hold_nx      = hold;
        ofifo_rd     = 1'b0;
        sram_cen     = 1'b1;
        sram_wen     = 1'b1;
        sram_d       = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    addr_nx      = base_addr;
                    remaining_nx = num_vec;
                    if (num_vec == '0)
                        state_nx = DONE;
                    else
                        state_nx = accum_en ? ACC_RD : PASS;
                end
            end
            PASS: begin
                if (ofifo_valid) begin
                    ofifo_rd     = 1'b1;
                    sram_cen     = 1'b0;
                    sram_wen     = 1'b0;
                    sram_d       = ofifo_data;
                    addr_nx      = addr + 1'b1;
                    remaining_nx = remaining - 1'b1;
                    if (last)
                        state_nx = DONE;
                end
            end
            ACC_RD: begin
                if (ofifo_valid) begin
                    ofifo_rd = 1'b1;
                    sram_cen = 1'b0;
                    hold_nx  = ofifo_data;
                    state_nx = ACC_WR;
                end
            end
            ACC_WR: begin
                // sram_q holds the old psum read in the previous cycle
                sram_cen     = 1'b0;
                sram_wen     = 1'b0;
                sram_d       = acc_sum;
                addr_nx      = addr + 1'b1;
                remaining_nx = remaining - 1'b1;
                state_nx     = last ? DONE : ACC_RD;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            hold      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            addr      <= addr_nx;
            remaining <= remaining_nx;
            hold      <= hold_nx;
            busy      <= (state_nx == PASS) || (state_nx == ACC_RD) ||
                         (state_nx == ACC_WR);
            done      <= (state_nx == DONE);
        end
    end

endmodule

// File: tb/tb_psum_writeback.sv
// Randomised bench for psum_writeback with an OFIFO/SRAM model
// and a transfer-level reference of expected SRAM writes.
module tb_psum_writeback;

    typedef struct {
        logic [10:0]  a;
        logic [127:0] v;
        bit           acc;
    } wr_t;

    typedef struct {
        int          c;
        logic [10:0] a;
    } log_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic [10:0]  base_addr;
    logic [10:0]  num_vec;
    logic         accum_en;
    logic         ofifo_valid;
    logic [127:0] ofifo_data;
    logic         ofifo_rd;
    logic         sram_cen;
    logic         sram_wen;
    logic [10:0]  sram_a;
    logic [127:0] sram_d;
    logic [127:0] sram_q;
    logic         busy;
    logic         done;

    psum_writeback dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .base_addr(base_addr),
        .num_vec(num_vec),
        .accum_en(accum_en),
        .ofifo_valid(ofifo_valid),
        .ofifo_data(ofifo_data),
        .ofifo_rd(ofifo_rd),
        .sram_cen(sram_cen),
        .sram_wen(sram_wen),
        .sram_a(sram_a),
        .sram_d(sram_d),
        .sram_q(sram_q),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [127:0] mem     [2048];
    logic [127:0] ref_mem [2048];
    logic [127:0] fifo_q  [$];
    logic [127:0] plan_q  [$];
    wr_t          exp_wr  [$];
    log_t         wr_log  [$];

    logic         s_reset = 1'b0;
    logic         s_start = 1'b0;
    logic [10:0]  s_base  = '0;
    logic [10:0]  s_num   = '0;
    logic         s_acc   = 1'b0;
    int           gmode   = 0;
    bit           tog     = 0;
    bit           rst_pending = 1;
    bit           done_next = 0;
    bit           prev_rd = 0;
    bit           saw_done = 0;
    bit           q_pend = 0;
    logic [127:0] q_next = '0;
    int           cyc = 0;
    int           n_pops = 0;
    int           n_rd = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    function automatic logic [15:0] sat16(input logic [15:0] a,
                                          input logic [15:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    function automatic logic [127:0] sat_vec(input logic [127:0] a,
                                             input logic [127:0] b);
        logic [127:0] r;
        for (int k = 0; k < 8; k++)
            r[k*16 +: 16] = sat16(a[k*16 +: 16], b[k*16 +: 16]);
        return r;
    endfunction

    function automatic logic [127:0] rand_vec();
        logic [127:0] r;
        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 3))
                0:       r[k*16 +: 16] = 16'h7F00 + 16'($urandom_range(0, 255));
                1:       r[k*16 +: 16] = 16'h8000 + 16'($urandom_range(0, 255));
                default: r[k*16 +: 16] = 16'($urandom);
            endcase
        end
        return r;
    endfunction

    task automatic flush();
        fifo_q.delete();
        plan_q.delete();
        exp_wr.delete();
        done_next = 0;
        prev_rd   = 0;
    endtask

    // Per-cycle comparison of DUT outputs against the transfer model.
    task automatic check();
        logic  wr;
        logic  rdm;
        logic  dexp;
        wr_t   e;
        logic [127:0] v;
        if (rst_pending) begin
            flush();
            chk("rst_ofifo_rd", ofifo_rd, 1'b0);
            chk("rst_cen", sram_cen, 1'b1);
            chk("rst_wen", sram_wen, 1'b1);
            chk("rst_a", sram_a, 11'd0);
            chk("rst_d", sram_d, 128'd0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_done", done, 1'b0);
        end else begin
            chk("busy", busy, exp_wr.size() > 0);
            dexp = done_next;
            done_next = 0;
            chk("done", done, dexp);
            if (done) saw_done = 1;
            wr  = !sram_cen && !sram_wen;
            rdm = !sram_cen && sram_wen;
            if (ofifo_rd) begin
                chk("rd_when_valid", ofifo_valid, 1'b1);
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                n_pops++;
            end
            if (exp_wr.size() == 0) begin
                chk("idle_strobes", {ofifo_rd, sram_cen, sram_wen}, 3'b011);
            end else begin
                e = exp_wr[0];
                if (!e.acc) begin
                    chk("pass_rd", ofifo_rd, ofifo_valid);
                    chk("pass_wr", {wr, rdm}, {ofifo_valid, 1'b0});
                end else if (prev_rd) begin
                    chk("acc_wr_cycle", {wr, rdm, ofifo_rd}, 3'b100);
                end else begin
                    chk("acc_rd_cycle", {wr, rdm, ofifo_rd},
                        {1'b0, ofifo_valid, ofifo_valid});
                end
                prev_rd = rdm;
                if (rdm) begin
                    chk("rd_addr", sram_a, e.a);
                    n_rd++;
                end
                if (wr) begin
                    v = e.acc ? sat_vec(ref_mem[e.a], e.v) : e.v;
                    chk("wr_addr", sram_a, e.a);
                    chk("wr_data", sram_d, v);
                    ref_mem[e.a] = v;
                    wr_log.push_back('{cyc, sram_a});
                    void'(exp_wr.pop_front());
                    if (exp_wr.size() == 0) done_next = 1;
                end
            end
            if (start && exp_wr.size() == 0 && !done_next && !dexp) begin
                for (int i = 0; i < int'(num_vec); i++) begin
                    if (plan_q.size() == 0) begin
                        chk("plan_short", 1'b0, 1'b1);
                    end else begin
                        exp_wr.push_back('{11'(int'(base_addr) + i),
                                           plan_q.pop_front(), accum_en});
                    end
                end
                prev_rd = 0;
                if (num_vec == 11'd0) done_next = 1;
            end
        end
        rst_pending = !reset;
        q_pend = 0;
        if (!sram_cen) begin
            if (!sram_wen) mem[sram_a] = sram_d;
            else begin
                q_pend = 1;
                q_next = mem[sram_a];
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        reset     = s_reset;
        start     = s_start;
        base_addr = s_base;
        num_vec   = s_num;
        accum_en  = s_acc;
        tog       = ~tog;
        ofifo_valid = (fifo_q.size() > 0) &&
                      ((gmode == 0) ? 1'b1 :
                       (gmode == 1) ? tog : ($urandom_range(0, 3) != 0));
        ofifo_data = (fifo_q.size() > 0) ? fifo_q[0]
                                         : {$urandom, $urandom, $urandom, $urandom};
        #1;
        check();
        @(posedge clk);
        if (q_pend) sram_q <= q_next;
        cyc++;
    endtask

    task automatic push_vec(input logic [127:0] v);
        fifo_q.push_back(v);
        plan_q.push_back(v);
    endtask

    task automatic set_mem(input logic [10:0] a, input logic [127:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    task automatic clear_logs();
        wr_log.delete();
        n_pops = 0;
        n_rd   = 0;
    endtask

    task automatic start_xfer(input logic [10:0] base, input logic [10:0] n,
                              input logic acc);
        saw_done = 0;
        s_base   = base;
        s_num    = n;
        s_acc    = acc;
        s_start  = 1'b1;
        step();
        s_start  = 1'b0;
        step();
    endtask

    task automatic wait_done(input int limit, input bit poke);
        int i = 0;
        while (!saw_done && i < limit) begin
            if (poke && exp_wr.size() > 1 && !s_start &&
                $urandom_range(0, 3) == 0) begin
                s_start = 1'b1;
                s_num   = 11'd3;
                s_base  = 11'($urandom);
                s_acc   = ~s_acc;
            end else begin
                s_start = 1'b0;
            end
            step();
            i++;
        end
        s_start = 1'b0;
        chk("done_timeout", saw_done, 1'b1);
    endtask

    initial begin
        logic [127:0] v;
        int guard;
        reset = 1'b0; start = 1'b0; base_addr = '0; num_vec = '0;
        accum_en = 1'b0; ofifo_valid = 1'b0; ofifo_data = '0; sram_q = '0;
        for (int a = 0; a < 2048; a++) set_mem(11'(a), rand_vec());

        s_reset = 1'b0;
        repeat (3) step();
        s_reset = 1'b1;
        repeat (2) step();

        chk("model_sat_hi", sat16(16'h7FF0, 16'h0020), 16'h7FFF);
        chk("model_sat_lo", sat16(16'h8010, 16'hFFE0), 16'h8000);
        chk("model_add", sat16(16'd100, 16'hFFE2), 16'd70);

        // overwrite, valid always high
        clear_logs();
        gmode = 0;
        repeat (3) push_vec(rand_vec());
        start_xfer(11'd5, 11'd3, 1'b0);
        wait_done(50, 0);
        chk("t1_pops", n_pops, 3);
        chk("t1_writes", wr_log.size(), 3);
        if (wr_log.size() == 3) begin
            chk("t1_a0", wr_log[0].a, 11'd5);
            chk("t1_a2", wr_log[2].a, 11'd7);
            chk("t1_consec", wr_log[2].c - wr_log[0].c, 2);
        end

        // stall with toggling valid, plus ignored starts while busy
        clear_logs();
        gmode = 1;
        repeat (4) push_vec(rand_vec());
        start_xfer(11'd100, 11'd4, 1'b0);
        wait_done(60, 1);
        chk("t2_writes", wr_log.size(), 4);
        if (wr_log.size() == 4)
            chk("t2_gap", wr_log[3].c - wr_log[2].c, 2);

        // accumulate 100 + (-30)
        clear_logs();
        gmode = 0;
        v = rand_vec();
        v[15:0] = 16'hFFE2;
        set_mem(11'd10, {rand_vec() >> 16, 16'd100});
        push_vec(v);
        start_xfer(11'd10, 11'd1, 1'b1);
        wait_done(20, 0);
        chk("t3_lane0", mem[10][15:0], 16'd70);
        chk("t3_reads", n_rd, 1);

        // saturation both directions
        v = rand_vec();
        v[31:0] = {16'hFFE0, 16'h0020};
        set_mem(11'd20, {rand_vec() >> 32, 16'h8010, 16'h7FF0});
        push_vec(v);
        start_xfer(11'd20, 11'd1, 1'b1);
        wait_done(20, 0);
        chk("t4_pos_sat", mem[20][15:0], 16'h7FFF);
        chk("t4_neg_sat", mem[20][31:16], 16'h8000);

        // zero-length transfer
        clear_logs();
        start_xfer(11'd300, 11'd0, 1'b0);
        chk("t5_zero_done", saw_done, 1'b1);
        step();
        chk("t5_zero_nowr", wr_log.size(), 0);

        // address wrap
        clear_logs();
        repeat (2) push_vec(rand_vec());
        start_xfer(11'd2047, 11'd2, 1'b0);
        wait_done(20, 0);
        chk("t5_wrap_n", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            chk("t5_wrap_a0", wr_log[0].a, 11'd2047);
            chk("t5_wrap_a1", wr_log[1].a, 11'd0);
        end

        // reset in the middle of an accumulate write
        clear_logs();
        repeat (4) push_vec(rand_vec());
        start_xfer(11'd400, 11'd4, 1'b1);
        guard = 0;
        while (n_rd < 2 && guard < 20) begin
            step();
            guard++;
        end
        chk("t6_reached_wr", n_rd, 2);
        s_reset = 1'b0;
        step();
        s_reset = 1'b1;
        repeat (3) step();
        chk("t6_no_done", saw_done, 1'b0);
        chk("t6_writes", wr_log.size(), 2);
        clear_logs();
        repeat (2) push_vec(rand_vec());
        start_xfer(11'd500, 11'd2, 1'b0);
        wait_done(20, 0);
        chk("t6_restart_n", wr_log.size(), 2);
        if (wr_log.size() == 2)
            chk("t6_restart_a", wr_log[1].a, 11'd501);

        // random mixed transfers
        gmode = 2;
        for (int t = 0; t < 25; t++) begin
            int n;
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++) push_vec(rand_vec());
            start_xfer(11'($urandom), 11'(n), 1'($urandom));
            wait_done(200, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
